seq_det_ctrl: RTL and testbench

//  Session controller for serial bit-pattern detection: arms a detection run from a start pulse, accepts a serial bit

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_ctrl_if.sv | 10 +
 rtl/pattern_match_core.sv | 47 ++++
 rtl/seq_det_ctrl.sv | 134 +++++++++++++
 tb/tb_seq_det_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the serial sequence-detection blocks.
// Holds the session state encoding and small helpers used by controllers.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A new session may only be launched from a quiescent state.
  function automatic logic start_allowed(state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Serial bit stream handshake between a bit source and the detector.
// The master offers din/din_valid; the slave answers with din_ready.
interface seq_det_ctrl_if;
  logic din;
  logic din_valid;
  logic din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/pattern_match_core.sv
// History shift register, fill counter and pattern compare for one stream.
// hit is combinational on the history that the current shift would produce.
module pattern_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  input  logic             clear,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL    = FW'(PAT_W);
  localparam logic [FW-1:0] FULL_M1 = FW'(PAT_W - 1);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [FW-1:0]    fill;

  assign hist_next = {hist[PAT_W-2:0], din};
  assign hit       = shift_en && (fill >= FULL_M1) && (hist_next == pattern);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the history is a handful of flops, not a RAM, so it is reset
      // like any other register; fill alone would gate stale bits anyway.
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_next;
      if (hit && !overlap)
        fill <= '0;
      else if (fill != FULL)
        fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sessioned controller for programmable serial pattern detection: arms on start,
// counts matches on the handshaked bit stream, ends on match limit, window or abort.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PAT_W-1:0]   cfg_pattern,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_match_limit,
  input  logic [WIN_W-1:0]   cfg_window,
  seq_det_ctrl_if.slave      stream,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  state_t state, next_state;

  logic [PAT_W-1:0] pat_q;
  logic             overlap_q;
  logic [CNT_W-1:0] limit_q;
  logic [WIN_W-1:0] window_q;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             hit;
  logic             start_go;
  logic [CNT_W-1:0] count_next;
  logic [WIN_W-1:0] win_next;
  logic             limit_end;
  logic             window_end;
  logic             session_end;

  // abort outranks the handshake: a bit offered alongside abort is dropped.
  assign accept   = (state == RUN) && stream.din_valid && !abort;
  assign start_go = start && !abort && start_allowed(state);

  assign count_next  = (hit && (count != '1)) ? count + CNT_W'(1) : count;
  assign win_next    = win_cnt + WIN_W'(1);
  assign limit_end   = accept && (limit_q != '0) && (count_next == limit_q);
  assign window_end  = accept && (window_q != '0) && (win_next == window_q);
  assign session_end = limit_end || window_end;

  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .din      (stream.din),
    .clear    (state == ARM),
    .overlap  (overlap_q),
    .pattern  (pat_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = ARM;
        ARM:     next_state = RUN;
        RUN:     if (session_end) next_state = DONE;
        DONE:    if (start) next_state = ARM;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    stream.din_ready = 1'b0;
    case (state)
      ARM:     busy = 1'b1;
      RUN:     begin busy = 1'b1; stream.din_ready = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q     <= '0;
      overlap_q <= 1'b0;
      limit_q   <= '0;
      window_q  <= '0;
      win_cnt   <= '0;
      count     <= '0;
      match     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      match <= accept && hit;
      if (start_go) begin
        pat_q     <= cfg_pattern;
        overlap_q <= cfg_overlap;
        limit_q   <= cfg_match_limit;
        window_q  <= cfg_window;
      end
      if (abort) begin
        timeout <= 1'b0;
      end else if (state == ARM) begin
        win_cnt <= '0;
        count   <= '0;
        timeout <= 1'b0;
      end else if (accept) begin
        count   <= count_next;
        win_cnt <= win_next;
        // A limit hit on the same bit as the window end takes precedence.
        if (session_end) timeout <= !limit_end;
      end
    end
  end

  assign match_count = count;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed sessions plus random sessions
// against a sliding-window reference model, with a match-pulse scoreboard.
module tb_seq_det_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_match_limit;
  logic [WIN_W-1:0] cfg_window;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             timeout;

  seq_det_ctrl_if bus ();

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .cfg_pattern     (cfg_pattern),
    .cfg_overlap     (cfg_overlap),
    .cfg_match_limit (cfg_match_limit),
    .cfg_window      (cfg_window),
    .stream          (bus),
    .match           (match),
    .match_count     (match_count),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected match_count for each match pulse, in order.
  int exp_q[$];

  // Reference model of one session.
  bit               seg[$];
  logic [PAT_W-1:0] m_pat;
  bit               m_ov;
  int               m_lim;
  int               m_winlim;
  int               m_count;
  int               m_win;
  bit               m_running;
  bit               m_done;
  bit               m_timeout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keeps the most recent bits since the last non-overlap match and compares
  // them against the pattern (first-received bit = pattern MSB).
  task automatic model_accept(input bit b);
    bit hit;
    seg.push_back(b);
    if (seg.size() > PAT_W) void'(seg.pop_front());
    hit = (seg.size() == PAT_W);
    for (int k = 0; k < seg.size(); k++)
      if (seg[k] != m_pat[PAT_W-1-k]) hit = 1'b0;
    m_win++;
    if (hit) begin
      if (m_count < CNT_MAX) m_count++;
      exp_q.push_back(m_count);
      if (!m_ov) seg.delete();
    end
    if (m_lim != 0 && m_count == m_lim) begin
      m_running = 1'b0; m_done = 1'b1; m_timeout = 1'b0;
    end else if (m_winlim != 0 && m_win == m_winlim) begin
      m_running = 1'b0; m_done = 1'b1; m_timeout = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (reset === 1'b0 && match === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_match: got match=1 with count %0d, required no pulse at %0t",
                 match_count, $time);
      end else begin
        e = exp_q.pop_front();
        check("match_count_at_pulse", 32'(match_count), e);
      end
    end
  end

  task automatic start_session(input logic [PAT_W-1:0] pat, input bit ov,
                               input int lim, input int win);
    @(negedge clk);
    cfg_pattern     = pat;
    cfg_overlap     = ov;
    cfg_match_limit = CNT_W'(lim);
    cfg_window      = WIN_W'(win);
    start           = 1'b1;
    m_pat = pat; m_ov = ov; m_lim = lim; m_winlim = win;
    seg.delete();
    m_count = 0; m_win = 0;
    m_running = 1'b0; m_done = 1'b0; m_timeout = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("arm_busy", 32'(busy), 1);
    check("arm_ready", 32'(bus.din_ready), 0);
    @(negedge clk);
    m_running = 1'b1;
    check("run_count_cleared", 32'(match_count), 0);
    check("run_done", 32'(done), 0);
    check("run_timeout", 32'(timeout), 0);
  endtask

  // Called at a negedge; returns at a negedge after gap idle cycles.
  task automatic offer_bit(input bit b, input bit ab, input int gap);
    bus.din       = b;
    bus.din_valid = 1'b1;
    abort         = ab;
    check("din_ready", 32'(bus.din_ready), 32'(m_running));
    if (m_running && !ab) model_accept(b);
    if (ab) begin
      m_running = 1'b0; m_done = 1'b0; m_timeout = 1'b0;
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    abort         = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_stream(input logic [63:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) offer_bit(bits[n-1-i], 1'b0, gap);
  endtask

  task automatic end_checks(input string tag);
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_timeout"}, 32'(timeout), 32'(m_timeout));
    check({tag, "_busy"}, 32'(busy), 32'(m_running));
    check({tag, "_ready"}, 32'(bus.din_ready), 32'(m_running));
    check({tag, "_count"}, 32'(match_count), m_count);
    check({tag, "_pending_matches"}, exp_q.size(), 0);
  endtask

  task automatic do_abort(input string tag);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    m_running = 1'b0; m_done = 1'b0; m_timeout = 1'b0;
    end_checks(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b0; cfg_match_limit = '0; cfg_window = '0;
    bus.din = 1'b0; bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.din_ready), 0);
    check("rst_match", 32'(match), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;

    // Overlapping matches, no end condition, then abort holds the count.
    start_session(4'b1010, 1'b1, 0, 0);
    run_stream(64'b1010101, 7, 0);
    end_checks("t1_run");
    do_abort("t1_abort");

    // Non-overlapping: second match would need four fresh bits.
    start_session(4'b1010, 1'b0, 0, 0);
    run_stream(64'b1010101, 7, 0);
    end_checks("t2_run");
    do_abort("t2_abort");

    // Limit of two ends the session; the seventh bit is refused.
    start_session(4'b1010, 1'b1, 2, 0);
    run_stream(64'b1010101, 7, 0);
    end_checks("t3_done");

    // Window end without matches, then limit and window on the same bit.
    start_session(4'b1111, 1'b1, 0, 5);
    run_stream(64'b10101, 5, 0);
    end_checks("t4_window");
    start_session(4'b1010, 1'b1, 1, 4);
    run_stream(64'b1010, 4, 0);
    end_checks("t4_both");

    // Valid gaps: idle cycles are not counted toward the window.
    start_session(4'b1010, 1'b1, 0, 4);
    run_stream(64'b1010, 4, 2);
    end_checks("t5_gaps");

    // Abort on the third bit drops it.
    start_session(4'b1010, 1'b1, 0, 0);
    offer_bit(1'b1, 1'b0, 0);
    offer_bit(1'b0, 1'b0, 0);
    offer_bit(1'b1, 1'b1, 0);
    end_checks("t6_abort");

    // start during RUN with a different pattern must be ignored.
    start_session(4'b1010, 1'b1, 0, 0);
    offer_bit(1'b1, 1'b0, 0);
    offer_bit(1'b0, 1'b0, 0);
    start = 1'b1; cfg_pattern = 4'b0101; cfg_overlap = 1'b0; cfg_match_limit = 8'd1;
    @(negedge clk);
    start = 1'b0;
    offer_bit(1'b1, 1'b0, 0);
    offer_bit(1'b0, 1'b0, 0);
    end_checks("t6_start_ignored");

    // Reset mid-RUN while a matching bit is offered: no pulse, back to IDLE.
    @(negedge clk);
    offer_bit(1'b1, 1'b0, 0);
    bus.din = 1'b0;
    bus.din_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    m_running = 1'b0; m_done = 1'b0; m_timeout = 1'b0; m_count = 0;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_ready", 32'(bus.din_ready), 0);
    check("t6_rst_count", 32'(match_count), 0);
    @(negedge clk);
    check("t6_rst_no_match", 32'(match), 0);
    bus.din_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("t6_after_rst_match", 32'(match), 0);
    check("t6_after_rst_pending", exp_q.size(), 0);

    // Random sessions against the reference model.
    for (int s = 0; s < 40; s++) begin
      logic [63:0] bits;
      int n;
      bits = {$urandom, $urandom};
      n = $urandom_range(4, 24);
      start_session(PAT_W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0);
      for (int i = 0; i < n; i++) offer_bit(bits[i], 1'b0, $urandom_range(0, 2));
      end_checks("rand_end");
      if (m_running) do_abort("rand_abort");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
